// File: rtl/burst_ecc_codec_pkg.sv
// Shared mode/state encodings and default code parameters for the burst ECC codec.
// Default code: shortened Fire code g(x) = (x^15+1)(x^9+x^4+1), 64/40, bursts up to 8.
package burst_ecc_codec_pkg;

  localparam logic [2:0] MODE_IDLE   = 3'b000;
  localparam logic [2:0] MODE_ENCODE = 3'b001;
  localparam logic [2:0] MODE_DECODE = 3'b010;

  localparam int          DEF_N      = 64;
  localparam int          DEF_K      = 40;
  localparam int          DEF_B      = 8;
  localparam int          DEF_PERIOD = 7665;
  localparam logic [23:0] DEF_G_POLY = 24'h088211;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ENC  = 3'd1,
    S_SYND = 3'd2,
    S_TRAP = 3'd3,
    S_OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/burst_ecc_codec_poly_mod_step.sv
// One serial GF(2) step modulo g(x): either shift a bit in (syndrome) or inject it into
// the feedback (systematic encode). With bit_in = 0 both forms reduce to t*x mod g.
module burst_ecc_codec_poly_mod_step #(
  parameter int         R      = 24,
  parameter logic [R-1:0] G_POLY = '0
) (
  input  logic [R-1:0] t_in,
  input  logic         bit_in,
  input  logic         fb_inject,
  output logic [R-1:0] t_out
);

  logic fb;

  always_comb begin
    fb    = t_in[R-1] ^ (fb_inject & bit_in);
    t_out = {t_in[R-2:0], bit_in & ~fb_inject} ^ (fb ? G_POLY : '0);
  end

endmodule

// File: rtl/burst_ecc_codec.sv
// Burst-error codec: serial parity / syndrome generation, then error trapping over one
// period of g(x). One request in flight; results are registered and held until out_ready.
module burst_ecc_codec
  import burst_ecc_codec_pkg::*;
#(
  parameter int             N      = DEF_N,
  parameter int             K      = DEF_K,
  parameter int             B      = DEF_B,
  parameter logic [N-K-1:0] G_POLY = (N-K)'(DEF_G_POLY),
  parameter int             PERIOD = DEF_PERIOD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         err_detected,
  output logic         err_uncorrectable,
  output logic         busy
);

  localparam int R  = N - K;
  localparam int CW = $clog2(PERIOD + 1);
  localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD);
  localparam logic [CW-1:0] LAST_ENC  = CW'(K - 1);
  localparam logic [CW-1:0] LAST_SYND = CW'(N - 1);
  localparam logic [CW-1:0] LAST_TRAP = CW'(PERIOD - 1);
  localparam logic [CW:0]   MAX_POS   = (CW + 1)'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   word_q, word_d;
  logic [R-1:0]   rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           det_q, det_d, unc_q, unc_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   data_out_q, data_out_d;
  logic           err_detected_q, err_detected_d;
  logic           err_uncorrectable_q, err_uncorrectable_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;

  logic           step_bit;
  logic [R-1:0]   step_out;
  logic [K-1:0]   enc_rot;
  logic [N-1:0]   synd_rot;
  logic [CW-1:0]  trap_j;
  logic [CW-1:0]  burst_msb;
  logic [N-1:0]   corrected;
  logic           trap_hit;

  burst_ecc_codec_poly_mod_step #(
    .R      (R),
    .G_POLY (G_POLY)
  ) u_step (
    .t_in      (rem_q),
    .bit_in    (step_bit),
    .fb_inject (state_q == S_ENC),
    .t_out     (step_out)
  );

  // Data rotates MSB-first through the word register and is back in place when the pass ends.
  always_comb begin
    enc_rot  = {word_q[K-2:0], word_q[K-1]};
    synd_rot = {word_q[N-2:0], word_q[N-1]};
    case (state_q)
      S_ENC:   step_bit = word_q[K-1];
      S_SYND:  step_bit = word_q[N-1];
      default: step_bit = 1'b0;
    endcase
  end

  // After i steps t = b * x^(i+j) mod g, so a trapped burst sits at j = (PERIOD - i) mod PERIOD.
  always_comb begin
    trap_j    = (cnt_q == '0) ? '0 : PERIOD_C - cnt_q;
    burst_msb = '0;
    for (int k = 0; k < B; k++) begin
      if (rem_q[k]) burst_msb = CW'(k);
    end
    trap_hit  = (rem_q[R-1:B] == '0) && rem_q[0] &&
                (({1'b0, trap_j} + {1'b0, burst_msb}) <= MAX_POS);
    corrected = word_q ^ ({{(N-B){1'b0}}, rem_q[B-1:0]} << trap_j);
  end

  always_comb begin
    state_d             = state_q;
    word_d              = word_q;
    rem_d               = rem_q;
    cnt_d               = cnt_q;
    det_d               = det_q;
    unc_d               = unc_q;
    out_valid_d         = out_valid_q;
    data_out_d          = data_out_q;
    err_detected_d      = err_detected_q;
    err_uncorrectable_d = err_uncorrectable_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d = data_in;
          rem_d  = '0;
          cnt_d  = '0;
          det_d  = 1'b0;
          unc_d  = 1'b0;
          case (mode)
            MODE_ENCODE: state_d = S_ENC;
            MODE_DECODE: state_d = S_SYND;
            MODE_IDLE:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
          endcase
        end
      end
      S_ENC: begin
        rem_d  = step_out;
        cnt_d  = cnt_q + CW'(1);
        word_d = {word_q[N-1:K], enc_rot};
        if (cnt_q == LAST_ENC) begin
          word_d  = {enc_rot, step_out};
          state_d = S_OUT;
        end
      end
      S_SYND: begin
        rem_d  = step_out;
        cnt_d  = cnt_q + CW'(1);
        word_d = synd_rot;
        if (cnt_q == LAST_SYND) begin
          cnt_d = '0;
          if (step_out == '0) begin
            word_d  = {{R{1'b0}}, synd_rot[N-1:R]};
            state_d = S_OUT;
          end else begin
            det_d   = 1'b1;
            state_d = S_TRAP;
          end
        end
      end
      S_TRAP: begin
        if (trap_hit) begin
          word_d  = {{R{1'b0}}, corrected[N-1:R]};
          state_d = S_OUT;
        end else begin
          rem_d = step_out;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_TRAP) begin
            unc_d   = 1'b1;
            word_d  = {{R{1'b0}}, word_q[N-1:R]};
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d         = 1'b1;
          data_out_d          = word_q;
          err_detected_d      = det_q;
          err_uncorrectable_d = unc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= S_IDLE;
      word_q              <= '0;
      rem_q               <= '0;
      cnt_q               <= '0;
      det_q               <= 1'b0;
      unc_q               <= 1'b0;
      out_valid_q         <= 1'b0;
      data_out_q          <= '0;
      err_detected_q      <= 1'b0;
      err_uncorrectable_q <= 1'b0;
      in_ready_q          <= 1'b1;
      busy_q              <= 1'b0;
    end else begin
      state_q             <= state_d;
      word_q              <= word_d;
      rem_q               <= rem_d;
      cnt_q               <= cnt_d;
      det_q               <= det_d;
      unc_q               <= unc_d;
      out_valid_q         <= out_valid_d;
      data_out_q          <= data_out_d;
      err_detected_q      <= err_detected_d;
      err_uncorrectable_q <= err_uncorrectable_d;
      in_ready_q          <= in_ready_d;
      busy_q              <= busy_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign data_out          = data_out_q;
  assign err_detected      = err_detected_q;
  assign err_uncorrectable = err_uncorrectable_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_burst_ecc_codec.sv
// Self-checking bench for burst_ecc_codec: spec vectors, hand-written corner sequences and
// random traffic against a polynomial-division / burst-search reference model.
module tb_burst_ecc_codec;

  localparam int N = 64;
  localparam int K = 40;
  localparam int R = 24;
  localparam int B = 8;
  localparam int PERIOD = 7665;
  localparam logic [R-1:0] G_POLY = 24'h088211;
  localparam logic [N-1:0] G_FULL = {{(N-R-1){1'b0}}, 1'b1, G_POLY};
  localparam logic [2:0] M_ENC = 3'b001;
  localparam logic [2:0] M_DEC = 3'b010;
  localparam int BUDGET = 1 + N + PERIOD + 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] data_out;
  logic         err_detected;
  logic         err_uncorrectable;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int txn_no = 0;

  always #5 clk = ~clk;

  burst_ecc_codec dut (
    .clk               (clk),
    .rst               (rst),
    .mode              (mode),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .data_in           (data_in),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .data_out          (data_out),
    .err_detected      (err_detected),
    .err_uncorrectable (err_uncorrectable),
    .busy              (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [R-1:0] gf2_mod(input logic [N-1:0] v);
    logic [N-1:0] m;
    m = v;
    for (int d = N - 1; d >= R; d--) begin
      if (m[d]) m = m ^ (G_FULL << (d - R));
    end
    return m[R-1:0];
  endfunction

  function automatic logic [N-1:0] model_encode(input logic [K-1:0] d);
    return {d, gf2_mod({d, {R{1'b0}}})};
  endfunction

  // Searches burst hypotheses in trapping order: position 0, then N-1 down to 1.
  task automatic model_decode(input logic [N-1:0] r, output logic [N-1:0] dout,
                              output logic det, output logic unc, output int lat);
    logic [R-1:0] s;
    logic [N-1:0] pat;
    logic [N-1:0] fix;
    logic [N-1:0] corr;
    logic         found;
    int           jj;
    int           fj;
    s     = gf2_mod(r);
    det   = (s != '0);
    found = 1'b0;
    fj    = 0;
    fix   = '0;
    if (det) begin
      for (int k = 0; k < N && !found; k++) begin
        jj = (k == 0) ? 0 : N - k;
        for (int b = 1; b < (1 << B) && !found; b += 2) begin
          if (jj + ($clog2(b + 1) - 1) <= N - 1) begin
            pat = N'(b) << jj;
            if (gf2_mod(pat) == s) begin
              found = 1'b1;
              fj    = jj;
              fix   = pat;
            end
          end
        end
      end
    end
    corr = r ^ fix;
    dout = {{R{1'b0}}, corr[N-1:R]};
    unc  = det && !found;
    if (!det) lat = N + 1;
    else if (found) lat = N + 2 + ((fj == 0) ? 0 : PERIOD - fj);
    else lat = N + 1 + PERIOD;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [2:0] m, input logic [N-1:0] d, input int hold,
                         output logic [N-1:0] dout, output logic det, output logic unc,
                         output int lat);
    logic [N-1:0] first;
    logic         stable;
    @(negedge clk);
    for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
    chk("in_ready_idle", N'(in_ready), N'(1));
    mode     = m;
    data_in  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode     = 3'($urandom);
    data_in  = {$urandom, $urandom};
    lat      = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    dout = data_out;
    det  = err_detected;
    unc  = err_uncorrectable;
    txn_no++;
    $display("txn %0d mode=%0d din=%h dout=%h det=%0d unc=%0d lat=%0d",
             txn_no, m, d, dout, det, unc, lat);
    if (lat > 0) begin
      chk("in_ready_while_valid", N'(in_ready), N'(0));
      first  = data_out;
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        if (!out_valid || data_out !== first || in_ready || !busy) stable = 1'b0;
      end
      if (hold > 0) chk("hold_stable", N'(stable), N'(1));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid_after_hs", N'(out_valid), N'(0));
      chk("in_ready_after_hs", N'(in_ready), N'(1));
    end
  endtask

  task automatic check_txn(input string name, input logic [2:0] m, input logic [N-1:0] d,
                           input int hold, input logic [N-1:0] e_dout, input logic e_det,
                           input logic e_unc, input int e_lat);
    logic [N-1:0] dout;
    logic         det;
    logic         unc;
    int           lat;
    run_txn(m, d, hold, dout, det, unc, lat);
    chk({name, "_dout"}, dout, e_dout);
    chk({name, "_det"}, N'(det), N'(e_det));
    chk({name, "_unc"}, N'(unc), N'(e_unc));
    chk({name, "_lat"}, N'(lat), N'(e_lat));
  endtask

  task automatic check_encode(input string name, input logic [K-1:0] d, input int hold);
    check_txn(name, M_ENC, {{R{1'b0}}, d}, hold, model_encode(d), 1'b0, 1'b0, K + 1);
  endtask

  task automatic check_decode(input string name, input logic [N-1:0] r);
    logic [N-1:0] e_dout;
    logic         e_det;
    logic         e_unc;
    int           e_lat;
    model_decode(r, e_dout, e_det, e_unc, e_lat);
    check_txn(name, M_DEC, r, 0, e_dout, e_det, e_unc, e_lat);
  endtask

  typedef struct {
    logic [2:0]   mode;
    logic [N-1:0] din;
    logic [N-1:0] exp_dout;
    logic         exp_det;
    logic         exp_unc;
    int           exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [N-1:0] cw1;
    logic [N-1:0] cw2;
    logic [N-1:0] md;
    logic         mdet;
    logic         munc;
    int           mlat;
    logic [N-1:0] burst;
    logic         quiet;
    logic [2:0]   drop_modes [2];

    rst       = 1'b1;
    mode      = 3'b000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;

    cw1 = model_encode(40'hDD5486AA91);
    cw2 = model_encode(40'h9D54A6AA99);
    vecs[0] = '{M_ENC, {24'h0, 40'hDD5486AA91}, cw1, 1'b0, 1'b0, K + 1};
    vecs[1] = '{M_DEC, cw1 ^ (64'hFF << 56), 64'h0000_00DD_5486_AA91, 1'b1, 1'b0,
                N + 2 + PERIOD - 56};
    vecs[2] = '{M_ENC, {24'h0, 40'h9D54A6AA99}, cw2, 1'b0, 1'b0, K + 1};
    vecs[3] = '{M_DEC, cw2 ^ (64'hFF << 20), 64'h0000_009D_54A6_AA99, 1'b1, 1'b0,
                N + 2 + PERIOD - 20};
    vecs[4] = '{M_DEC, cw2, 64'h0000_009D_54A6_AA99, 1'b0, 1'b0, N + 1};
    model_decode(cw1 ^ (64'hFF << 56) ^ 64'hFF, md, mdet, munc, mlat);
    vecs[5] = '{M_DEC, cw1 ^ (64'hFF << 56) ^ 64'hFF, md, mdet, munc, mlat};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", N'(in_ready), N'(1));
    chk("reset_out_valid", N'(out_valid), N'(0));
    chk("reset_busy", N'(busy), N'(0));
    chk("reset_data_out", data_out, '0);
    chk("reset_err", N'({err_detected, err_uncorrectable}), N'(0));
    @(negedge clk);
    rst = 1'b0;

    chk("spec_parity_upper", cw1 >> R, N'(40'hDD5486AA91));
    for (int i = 0; i < 6; i++) begin
      check_txn($sformatf("vec%0d", i), vecs[i].mode, vecs[i].din, 0, vecs[i].exp_dout,
                vecs[i].exp_det, vecs[i].exp_unc, vecs[i].exp_lat);
    end

    // Back-pressure: result must hold for 20 cycles with out_ready low.
    check_encode("hold_enc", 40'(({$urandom, $urandom})), 20);

    // Requests with idle/reserved mode are swallowed without output.
    drop_modes[0] = 3'b111;
    drop_modes[1] = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mode     = drop_modes[i];
      data_in  = {$urandom, $urandom};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      quiet    = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (out_valid || busy || !in_ready) quiet = 1'b0;
        @(posedge clk);
        #1;
      end
      chk($sformatf("drop_mode%0d", drop_modes[i]), N'(quiet), N'(1));
    end

    // Random encodes and clean/parity-burst decodes.
    for (int i = 0; i < 12; i++) check_encode("rnd_enc", 40'(({$urandom, $urandom})), 0);
    for (int i = 0; i < 5; i++) check_decode("rnd_clean", model_encode(40'(({$urandom, $urandom}))));
    for (int i = 0; i < 5; i++) begin
      burst = N'(($urandom_range(0, 127) << 1) | 1);
      check_decode("rnd_burst0", model_encode(40'(({$urandom, $urandom}))) ^ burst);
    end
    for (int i = 0; i < 2; i++) begin
      burst = N'(($urandom_range(0, 127) << 1) | 1) << $urandom_range(1, N - B);
      check_decode("rnd_burst", model_encode(40'(({$urandom, $urandom}))) ^ burst);
    end
    check_decode("rnd_word", {$urandom, $urandom});

    // Asynchronous reset in the middle of error trapping.
    @(negedge clk);
    mode     = M_DEC;
    data_in  = cw1 ^ (64'hFF << 56);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (150) @(posedge clk);
    #3;
    chk("trap_busy", N'(busy), N'(1));
    rst = 1'b1;
    #1;
    chk("async_rst_busy", N'(busy), N'(0));
    chk("async_rst_in_ready", N'(in_ready), N'(1));
    chk("async_rst_out_valid", N'(out_valid), N'(0));
    chk("async_rst_data_out", data_out, '0);
    chk("async_rst_err", N'({err_detected, err_uncorrectable}), N'(0));
    @(negedge clk);
    rst = 1'b0;
    check_encode("post_rst_enc", 40'(({$urandom, $urandom})), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
